// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack sequencer: operation codes, FSM
// encoding, default stack depth and ULA flag bit positions.
package rpn_pkg;

    localparam int PROFUNDIDADE_PADRAO = 4;
    localparam int LARGURA             = 8;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_NOT    = 3'b101,
        OP_STORE  = 3'b110,
        OP_RECALL = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        OCIOSO,
        DECODIFICA,
        EMPILHA,
        EXECUTA,
        GRAVA,
        ERRO
    } estado_t;

    // ula_flags = {erro, carry, overflow, zero}
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_ERRO     = 3;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector. The history flop resets to 1 so a level that is
// already high when reset is released is not seen as a new press.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic nivel,
    output logic borda
);

    logic anterior;

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses <=, so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) anterior <= 1'b1;
        else     anterior <= nivel;
    end

    assign borda = nivel & ~anterior;

endmodule

// File: rtl/sequenciador_rpn.sv
// RPN stack sequencer: push/op/clear buttons drive a small operand stack,
// an external ULA and a one-word external memory.
module sequenciador_rpn
    import rpn_pkg::*;
#(
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dado_in,
    input  logic       push_req,
    input  logic       op_req,
    input  logic [2:0] op_code,
    input  logic       clear_req,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [2:0] ula_sel,
    input  logic [7:0] ula_res,
    input  logic [3:0] ula_flags,
    output logic       mem_wr,
    output logic [7:0] mem_dado,
    input  logic [7:0] mem_rd_dado,
    output logic [7:0] topo,
    output logic [7:0] segundo,
    output logic [3:0] profundidade,
    output logic       pilha_vazia,
    output logic       pilha_cheia,
    output logic       ocupado,
    output logic       erro_pilha,
    output logic [3:0] flags_reg
);

    logic       push_borda, op_borda, clear_borda;
    logic       push_dispara, op_dispara;
    estado_t    estado, estado_prox;
    logic       eh_push;
    op_t        op_atual;
    logic [7:0] pilha [PROFUNDIDADE];
    logic [3:0] prof;

    detector_borda u_borda_push  (.clk(clk), .rst(rst), .nivel(push_req),  .borda(push_borda));
    detector_borda u_borda_op    (.clk(clk), .rst(rst), .nivel(op_req),    .borda(op_borda));
    detector_borda u_borda_clear (.clk(clk), .rst(rst), .nivel(clear_req), .borda(clear_borda));

    // Push wins over a simultaneous op; anything arriving while busy is dropped.
    assign push_dispara = push_borda & ~ocupado;
    assign op_dispara   = op_borda & ~ocupado & ~push_dispara;

    assign pilha_vazia  = (prof == 4'd0);
    assign pilha_cheia  = (prof == 4'(PROFUNDIDADE));
    assign ocupado      = (estado != OCIOSO);
    assign erro_pilha   = (estado == ERRO);
    assign mem_wr       = (estado == EMPILHA) && !eh_push && (op_atual == OP_STORE);
    assign topo         = pilha[0];
    assign segundo      = pilha[1];
    assign profundidade = prof;

    always_ff @(posedge clk) begin
        if (rst || clear_borda) estado <= OCIOSO;
        else                    estado <= estado_prox;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves estado_prox unassigned
        // (which would infer a latch).
        estado_prox = estado;
        case (estado)
            OCIOSO:     if (push_dispara || op_dispara) estado_prox = DECODIFICA;
            DECODIFICA: begin
                if (eh_push) begin
                    estado_prox = pilha_cheia ? ERRO : EMPILHA;
                end else begin
                    case (op_atual)
                        OP_NOT:    estado_prox = pilha_vazia ? ERRO : EXECUTA;
                        OP_STORE:  estado_prox = pilha_vazia ? ERRO : EMPILHA;
                        OP_RECALL: estado_prox = pilha_cheia ? ERRO : EMPILHA;
                        default:   estado_prox = (prof >= 4'd2) ? EXECUTA : ERRO;
                    endcase
                end
            end
            EXECUTA: estado_prox = GRAVA;
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the stack is a handful of flops, not a RAM, so it is reset
            // entry by entry; vacated and reset entries must read zero.
            for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
            prof      <= '0;
            flags_reg <= '0;
            ula_a     <= '0;
            ula_b     <= '0;
            ula_sel   <= '0;
            mem_dado  <= '0;
            eh_push   <= 1'b0;
            op_atual  <= OP_ADD;
        end else if (clear_borda) begin
            for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
            prof      <= '0;
            flags_reg <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (push_dispara || op_dispara) begin
                        eh_push  <= push_dispara;
                        op_atual <= op_t'(op_code);
                    end
                end
                DECODIFICA: begin
                    if (estado_prox == EXECUTA) begin
                        ula_sel <= op_atual;
                        if (op_atual == OP_NOT) begin
                            ula_a <= pilha[0];
                            ula_b <= '0;
                        end else begin
                            ula_a <= pilha[1];
                            ula_b <= pilha[0];
                        end
                    end
                    if (estado_prox == EMPILHA && !eh_push && op_atual == OP_STORE)
                        mem_dado <= pilha[0];
                end
                EMPILHA: begin
                    if (eh_push || op_atual == OP_RECALL) begin
                        for (int i = PROFUNDIDADE - 1; i > 0; i--) pilha[i] <= pilha[i-1];
                        pilha[0] <= eh_push ? dado_in : mem_rd_dado;
                        prof     <= prof + 4'd1;
                    end
                end
                GRAVA: begin
                    flags_reg <= ula_flags;
                    if (op_atual != OP_NOT) begin
                        for (int i = 1; i < PROFUNDIDADE - 1; i++) pilha[i] <= pilha[i+1];
                        pilha[PROFUNDIDADE-1] <= '0;
                        prof <= prof - 4'd1;
                    end
                    pilha[0] <= ula_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_rpn.sv
// Directed bench for sequenciador_rpn with a behavioural ULA and a one-word
// memory; expected values are hand-computed per scenario.
module tb_sequenciador_rpn;
    import rpn_pkg::*;

    logic       clk = 1'b0;
    logic       rst, push_req, op_req, clear_req;
    logic [7:0] dado_in, mem_rd_dado, ula_a, ula_b, ula_res, mem_dado, topo, segundo;
    logic [2:0] op_code, ula_sel;
    logic [3:0] ula_flags, profundidade, flags_reg;
    logic       mem_wr, pilha_vazia, pilha_cheia, ocupado, erro_pilha;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    logic [7:0] mem_q = 8'h00;
    logic [8:0] ula_ext;

    sequenciador_rpn #(.PROFUNDIDADE(4)) dut (
        .clk(clk), .rst(rst), .dado_in(dado_in), .push_req(push_req),
        .op_req(op_req), .op_code(op_code), .clear_req(clear_req),
        .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_res(ula_res),
        .ula_flags(ula_flags), .mem_wr(mem_wr), .mem_dado(mem_dado),
        .mem_rd_dado(mem_rd_dado), .topo(topo), .segundo(segundo),
        .profundidade(profundidade), .pilha_vazia(pilha_vazia),
        .pilha_cheia(pilha_cheia), .ocupado(ocupado), .erro_pilha(erro_pilha),
        .flags_reg(flags_reg)
    );

    always #5 clk = ~clk;

    always_comb begin
        ula_ext   = '0;
        ula_flags = '0;
        case (ula_sel)
            3'b000:  ula_ext = {1'b0, ula_a} + {1'b0, ula_b};
            3'b001:  ula_ext = {1'b0, ula_a} - {1'b0, ula_b};
            3'b010:  ula_ext = {1'b0, ula_a & ula_b};
            3'b011:  ula_ext = {1'b0, ula_a | ula_b};
            3'b100:  ula_ext = {1'b0, ula_a ^ ula_b};
            3'b101:  ula_ext = {1'b0, ~ula_a};
            default: ula_flags[FLAG_ERRO] = 1'b1;
        endcase
        ula_res                  = ula_ext[7:0];
        ula_flags[FLAG_CARRY]    = ula_ext[8];
        ula_flags[FLAG_ZERO]     = (ula_ext[7:0] == 8'h00);
        ula_flags[FLAG_OVERFLOW] = (ula_sel == 3'b000) ? (ula_a[7] == ula_b[7]) && (ula_res[7] != ula_a[7]) :
                                   (ula_sel == 3'b001) ? (ula_a[7] != ula_b[7]) && (ula_res[7] != ula_a[7]) : 1'b0;
    end

    // One-word memory; written mid-cycle so it never races the DUT edge.
    always @(negedge clk) begin
        if (mem_wr) begin
            mem_q <= mem_dado;
            n_wr  <= n_wr + 1;
        end
    end
    assign mem_rd_dado = mem_q;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [7:0] v);
        dado_in  = v;
        push_req = 1'b1;
        tick();
        push_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_op(input logic [2:0] c);
        op_code = c;
        op_req  = 1'b1;
        tick();
        op_req  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; push_req = 1'b0; op_req = 1'b0; clear_req = 1'b0;
        dado_in = 8'h00; op_code = 3'b000;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_topo", topo, 0);
        check("rst_prof", profundidade, 0);
        check("rst_vazia", pilha_vazia, 1);
        check("rst_cheia", pilha_cheia, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_ula", {ula_a, ula_b, 5'd0, ula_sel}, 0);
        check("rst_flags", flags_reg, 0);

        // 5 + 3 with exact latency
        do_push(8'h05);
        do_push(8'h03);
        check("push2_topo", topo, 8'h03);
        check("push2_segundo", segundo, 8'h05);
        op_code = 3'b000; op_req = 1'b1;
        tick();
        op_req = 1'b0;
        check("add_ocupado", ocupado, 1);
        tick();
        check("add_ula_a", ula_a, 8'h05);
        check("add_ula_b", ula_b, 8'h03);
        check("add_ula_sel", ula_sel, 3'b000);
        tick();
        check("add_not_yet", topo, 8'h03);
        tick();
        check("add_topo", topo, 8'h08);
        check("add_prof", profundidade, 1);
        check("add_vacated", segundo, 8'h00);
        check("add_flags", flags_reg, 4'b0000);

        do_push(8'h08);
        do_op(3'b001);
        check("sub_topo", topo, 8'h00);
        check("sub_flags", flags_reg, 4'b0001);
        do_op(3'b101);
        check("not_topo", topo, 8'hFF);
        check("not_prof", profundidade, 1);
        check("not_sel", ula_sel, 3'b101);
        do_push(8'h01);
        do_op(3'b000);
        check("addc_topo", topo, 8'h00);
        check("addc_flags", flags_reg, 4'b0101);
        do_clear();
        check("clr_prof", profundidade, 0);
        check("clr_flags", flags_reg, 0);
        check("clr_vazia", pilha_vazia, 1);

        // op on empty stack
        op_code = 3'b001; op_req = 1'b1;
        tick();
        op_req = 1'b0;
        tick();
        check("empty_erro", erro_pilha, 1);
        tick();
        check("empty_erro_off", erro_pilha, 0);
        check("empty_ocupado", ocupado, 0);
        check("empty_sel", ula_sel, 3'b000);
        check("empty_prof", profundidade, 0);
        do_push(8'h07);
        check("after_err_topo", topo, 8'h07);

        // store / recall
        do_clear();
        do_push(8'h2A);
        op_code = 3'b110; op_req = 1'b1;
        tick();
        op_req = 1'b0;
        tick();
        check("store_wr", mem_wr, 1);
        check("store_dado", mem_dado, 8'h2A);
        tick();
        check("store_wr_off", mem_wr, 0);
        check("store_prof", profundidade, 1);
        do_op(3'b111);
        check("recall_prof", profundidade, 2);
        check("recall_topo", topo, 8'h2A);
        check("recall_segundo", segundo, 8'h2A);
        check("mem_wr_count", n_wr, 1);

        // overflow push, then logic ops draining the full stack
        do_clear();
        do_push(8'h01); do_push(8'h02); do_push(8'h03); do_push(8'h04);
        check("full_cheia", pilha_cheia, 1);
        dado_in = 8'h09; push_req = 1'b1;
        tick();
        push_req = 1'b0;
        tick();
        check("full_erro", erro_pilha, 1);
        tick();
        check("full_topo", topo, 8'h04);
        check("full_segundo", segundo, 8'h03);
        check("full_prof", profundidade, 4);
        check("full_cheia2", pilha_cheia, 1);
        do_op(3'b010);
        check("and_topo", topo, 8'h00);
        check("and_segundo", segundo, 8'h02);
        check("and_prof", profundidade, 3);
        do_op(3'b011);
        check("or_topo", topo, 8'h02);
        check("or_segundo", segundo, 8'h01);
        do_op(3'b100);
        check("xor_topo", topo, 8'h03);
        check("xor_segundo", segundo, 8'h00);
        check("xor_prof", profundidade, 1);

        // push and op in the same cycle
        do_clear();
        do_push(8'h22);
        dado_in = 8'h11; op_code = 3'b000; push_req = 1'b1; op_req = 1'b1;
        tick();
        push_req = 1'b0; op_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("both_prof", profundidade, 2);
        check("both_topo", topo, 8'h11);
        check("both_segundo", segundo, 8'h22);

        // reset in the middle of EXECUTA
        op_code = 3'b000; op_req = 1'b1;
        tick();
        op_req = 1'b0;
        tick();
        check("mid_ula_a", ula_a, 8'h22);
        check("mid_ula_b", ula_b, 8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_stack", {topo, segundo}, 0);
        check("mid_rst_prof", profundidade, 0);
        check("mid_rst_ula", {ula_a, ula_b, 5'd0, ula_sel}, 0);
        check("mid_rst_mem", {mem_dado, 7'd0, mem_wr}, 0);
        check("mid_rst_ocupado", ocupado, 0);
        tick(); tick();
        check("mid_no_grava", topo, 8'h00);
        check("mid_no_flags", flags_reg, 0);

        // button held across reset release
        dado_in = 8'h5C; push_req = 1'b1; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        check("held_prof", profundidade, 0);
        check("held_ocupado", ocupado, 0);
        push_req = 1'b0;
        tick();
        do_push(8'h5C);
        tick(); tick(); tick();
        check("held_push_topo", topo, 8'h5C);
        check("held_push_prof", profundidade, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
